// File: rtl/nmr_bstrm_pkg.sv
`default_nettype none
// ============================================================================
// nmr_bstrm_pkg : shared types and constants for the NMR bitstream datapath
// Revision 1.0
// ============================================================================
package nmr_bstrm_pkg;

    localparam int SEL_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dpath_state_t;

endpackage
`default_nettype wire

// File: rtl/nmr_bstrm_mux.sv
`default_nettype none
// ============================================================================
// nmr_bstrm_mux : MUX_WIDTH:1 one-bit mux, out-of-range selects input 0
// Revision 1.0
// ============================================================================
module nmr_bstrm_mux
    import nmr_bstrm_pkg::*;
#(
    parameter int MUX_WIDTH = 16
) (
    input  logic [MUX_WIDTH-1:0] in_vec,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic                 mux_out
);

    // Any select that matches no input falls through to input 0.
    always_comb begin
        mux_out = in_vec[0];
        for (int i = 1; i < MUX_WIDTH; i++) begin
            if (int'(sel) == i) begin
                mux_out = in_vec[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nmr_bstrm_simp_dpath.sv
`default_nettype none
// ============================================================================
// nmr_bstrm_simp_dpath : segment counter/FSM driving the pulse line, plus mux
// Revision 1.0
// ============================================================================
module nmr_bstrm_simp_dpath
    import nmr_bstrm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MUX_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  DPATH_RDY,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PLS_POL,
    input  logic [SEL_WIDTH-1:0]  mux_sel,
    input  logic [MUX_WIDTH-2:0]  mux_in,
    output logic                  OUT
);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    dpath_state_t          state;
    dpath_state_t          state_nxt;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] cnt_nxt;
    logic                  lvl;
    logic                  lvl_nxt;
    logic                  load;

    // Ready in idle, and on the final cycle of a segment so the next one
    // can be chained without a gap.
    assign DPATH_RDY = (state == IDLE) || (cnt == CNT_ONE);
    assign load      = START && DPATH_RDY && (data != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lvl   <= lvl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lvl_nxt   = lvl;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = RUN;
                    cnt_nxt   = data;
                    lvl_nxt   = PLS_POL;
                end
            end
            RUN: begin
                if (cnt == CNT_ONE) begin
                    if (load) begin
                        cnt_nxt = data;
                        lvl_nxt = PLS_POL;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    nmr_bstrm_mux #(
        .MUX_WIDTH (MUX_WIDTH)
    ) u_mux (
        .in_vec  ({mux_in, lvl}),
        .sel     (mux_sel),
        .mux_out (OUT)
    );

endmodule
`default_nettype wire

// File: tb/tb_nmr_bstrm_simp_dpath.sv
`default_nettype none
// ============================================================================
// tb_nmr_bstrm_simp_dpath : directed + random bench with a per-cycle level queue model
// Revision 1.0
// ============================================================================
module tb_nmr_bstrm_simp_dpath;

    localparam int DATA_WIDTH = 32;
    localparam int MUX_WIDTH  = 16;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  START = 1'b0;
    logic                  DPATH_RDY;
    logic [DATA_WIDTH-1:0] data = '0;
    logic                  PLS_POL = 1'b0;
    logic [3:0]            mux_sel = '0;
    logic [MUX_WIDTH-2:0]  mux_in = '0;
    logic                  OUT;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one queue entry per future cycle of the pulse line; once drained
    // the line holds the level of the last finished segment.
    logic q[$];
    logic last_lvl = 1'b0;

    nmr_bstrm_simp_dpath #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUX_WIDTH  (MUX_WIDTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DPATH_RDY (DPATH_RDY),
        .data      (data),
        .PLS_POL   (PLS_POL),
        .mux_sel   (mux_sel),
        .mux_in    (mux_in),
        .OUT       (OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic exp_lvl();
        return (q.size() > 0) ? q[0] : last_lvl;
    endfunction

    function automatic logic exp_rdy();
        return q.size() <= 1;
    endfunction

    function automatic logic exp_out(input logic [3:0] s, input logic [MUX_WIDTH-2:0] m);
        if (s == 0 || int'(s) >= MUX_WIDTH) return exp_lvl();
        return m[int'(s) - 1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic r, input logic s, input logic [31:0] d,
                        input logic p, input logic [3:0] sel, input logic [MUX_WIDTH-2:0] m);
        logic acc;
        @(negedge CLK);
        RST = r; START = s; data = d; PLS_POL = p; mux_sel = sel; mux_in = m;
        #1;
        check("rdy", {31'b0, DPATH_RDY}, {31'b0, exp_rdy()});
        check("out", {31'b0, OUT}, {31'b0, exp_out(sel, m)});
        acc = !r && s && exp_rdy() && (d != 0);
        @(posedge CLK);
        if (r) begin
            q.delete();
            last_lvl = 1'b0;
        end else begin
            if (q.size() > 0) last_lvl = q.pop_front();
            if (acc) for (int i = 0; i < int'(d); i++) q.push_back(p);
        end
    endtask

    int seg_len [5] = '{5, 5, 6, 6, 6};
    logic seg_pol [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int k;
        // Reset, with START asserted during reset
        step(1, 1, 4, 1, 0, '0);
        step(1, 1, 4, 1, 0, '0);
        check("rst_out", {31'b0, OUT}, 32'd0);
        check("rst_rdy", {31'b0, DPATH_RDY}, 32'd1);

        // Single segment length 4, high
        step(0, 1, 4, 1, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 0, 9, 0, 0, '0);
        check("hold_high", {31'b0, OUT}, 32'd1);

        // Mux with lvl=1
        step(0, 0, 0, 0, 3, 15'h0004);
        step(0, 0, 0, 0, 2, 15'h0004);
        step(0, 0, 0, 0, 3, 15'h0000);
        step(0, 0, 0, 0, 3, 15'h0004);
        step(0, 0, 0, 0, 0, 15'h7fff);

        // Back-to-back chain; START held while busy with junk data/polarity
        k = 0;
        while (k < 5) begin
            if (exp_rdy()) begin
                step(0, 1, seg_len[k], seg_pol[k], 0, '0);
                k++;
            end else begin
                step(0, 1, $urandom_range(1, 9), $urandom_range(0, 1), 0, '0);
            end
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, '0);

        // Edge lengths
        step(0, 1, 1, 1, 0, '0);
        step(0, 1, 1, 0, 0, '0);
        step(0, 1, 1, 1, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        check("zero_len_ignored", {31'b0, OUT}, 32'd1);

        // Reset mid-segment
        step(0, 1, 10, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        check("abort_out", {31'b0, OUT}, 32'd0);
        check("abort_rdy", {31'b0, DPATH_RDY}, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 6),
                 $urandom_range(0, 1), $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(0, 15)),
                 15'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nmr_bstrm_simp_dpath.md
# nmr_bstrm_simp_dpath

Datapath of the NMR bitstream generator. Each accepted START produces one constant-level segment on the pulse line, PLS_POL for exactly `data` clock cycles. A 16-way output multiplexer then selects either that pulse line or one of 15 static auxiliary inputs to drive OUT. A sequencer above it chains segments back-to-back using the DPATH_RDY handshake.

## Interface
- DATA_WIDTH, default 32: width of the segment length and down-counter.
- MUX_WIDTH, default 16: number of mux inputs; input 0 is the pulse line, inputs 1..MUX_WIDTH-1 come from mux_in.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request to load a new segment; sampled only when DPATH_RDY=1.
- DPATH_RDY  out  1  datapath can accept START on this edge.
- data  in  DATA_WIDTH  segment length in clock cycles (unsigned).
- PLS_POL  in  1  level of the segment (1 = high, 0 = low).
- mux_sel  in  4  output source select.
- mux_in  in  MUX_WIDTH-1  auxiliary sources; mux_in[i] is mux input i+1.
- OUT  out  1  selected bitstream output.

## Operation
- Registers: cnt (DATA_WIDTH), lvl (pulse line), state {IDLE, RUN}.
- IDLE: DPATH_RDY=1; lvl holds its last value.
- START=1 in IDLE and data≠0: load cnt←data, lvl←PLS_POL, go to RUN.
- START=1 in IDLE and data=0: ignored; no state change.
- RUN: cnt decrements every cycle. DPATH_RDY=1 only when cnt==1, the last cycle of the segment.
- RUN with cnt==1 and START=1 (data≠0): reload cnt←data, lvl←PLS_POL, stay in RUN. Segments are seamless, with no idle gap.
- RUN with cnt==1 and no valid START: go to IDLE; lvl keeps the polarity of the finished segment.
- START while DPATH_RDY=0: ignored.
- Mux: OUT = lvl when mux_sel=0; otherwise mux_in[mux_sel-1].
- mux_sel ≥ MUX_WIDTH selects 0.
- The mux is combinational from lvl, mux_sel and mux_in. It is not registered.

## Timing
- Reset values: state=IDLE, cnt=0, lvl=0, DPATH_RDY=1. OUT = mux result with lvl=0, which is 0 when mux_sel=0.
- RST has priority over START. Asserting RST mid-segment aborts the segment on the next edge.
- Latency: START sampled at edge k gives lvl=PLS_POL from cycle k+1 through cycle k+data, exactly `data` cycles.
- DPATH_RDY falls after edge k, except when data==1, where it stays high because that single cycle is also the last cycle. It rises during cycle k+data.
- data and PLS_POL are captured only at the accepting edge. Later changes to them do not affect the running segment.
- mux_sel and mux_in changes propagate to OUT in the same cycle, combinationally.
- Maximum segment length is 2^DATA_WIDTH−1 cycles. The counter never wraps.

## Structure
- Shared package nmr_bstrm_pkg holds the state enum (IDLE, RUN) and the mux select width constant (4).
- One sub-module, nmr_bstrm_mux: a parameterised MUX_WIDTH:1 one-bit mux with the out-of-range-selects-0 rule.
- The counter and FSM live in the top level.

## Test plan
- Reset: RST high for 2 cycles → DPATH_RDY=1, OUT=0 with mux_sel=0. START asserted during reset is ignored.
- Single segment: START with data=4, PLS_POL=1, mux_sel=0 → OUT high for exactly 4 cycles starting the cycle after START. DPATH_RDY low for 3 cycles, high on the 4th. OUT stays 1 afterwards.
- Back-to-back sequence of (5,0), (5,1), (6,0), (6,1), (6,0), each START issued when DPATH_RDY is seen high → OUT shows low 5, high 5, low 6, high 6, low 6 cycles with no gaps. START issued while busy changes nothing.
- Edge lengths: data=1 → one-cycle segment and DPATH_RDY never drops. data=0 → no effect.
- Mux: lvl=1, mux_in=15'h0004 → mux_sel=3 gives OUT=1, mux_sel=2 gives OUT=0. Toggling mux_in[2] follows on OUT the same cycle.
- Reset mid-segment: data=10, RST at cycle 4 → next cycle state=IDLE, lvl=0, DPATH_RDY=1.
